// File: rtl/mole_round_timer.sv
// mole_round_timer
// Round sequencer for the whac-a-mole scoring path. Each round shows a mole
// for a programmable hit window, holds timeUp for a few cycles, then pauses
// for a short gap. The mole position comes from a 5-bit LFSR that advances
// once per round, on the edge where timeUp falls. The first synchronized key
// press inside the hit window is captured for the score FSM.
//
// Build option:
//   WINDOW_SHRINK_EN - when defined, a shrink request seen during HOLD narrows
//                      the hit window by SHRINK_STEP ticks (floored at
//                      MIN_WINDOW). When undefined, shrink is ignored and the
//                      window stays at INIT_WINDOW.

module mole_round_timer #(
    parameter int         TICK_DIV    = 1000,
    parameter logic [7:0] INIT_WINDOW = 8'd40,
    parameter logic [7:0] MIN_WINDOW  = 8'd8,
    parameter logic [7:0] SHRINK_STEP = 8'd4,
    parameter int         HOLD_CYCLES = 4,
    parameter int         GAP_CYCLES  = 16
) (
    input  logic       systemClock,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] keys,
    input  logic       shrink,
    output logic       timeUp,
    output logic [1:0] mole,
    output logic [1:0] keyPressed,
    output logic       pressedInTime,
    output logic [7:0] window
);

    // Counter widths; a width of at least one bit keeps degenerate
    // parameter choices (TICK_DIV = 1) legal.
    localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 32'sd1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(32'sd1);
    localparam logic [PW-1:0] PRESC_ZERO = PW'(32'sd0);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 32'sd1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 32'sd1);
    localparam logic [CW-1:0] PHASE_ONE  = CW'(32'sd1);
    localparam logic [CW-1:0] PHASE_ZERO = CW'(32'sd0);
    localparam logic [4:0]    LFSR_SEED  = 5'b10001;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SHOW = 2'b01,
        HOLD = 2'b10,
        GAP  = 2'b11
    } state_t;

    // Lowest set bit wins when several keys rise in the same cycle.
    function automatic logic [1:0] lowest_index(input logic [3:0] vec);
        logic [1:0] idx;
        if (vec[0]) begin
            idx = 2'd0;
        end else if (vec[1]) begin
            idx = 2'd1;
        end else if (vec[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

    // One Fibonacci step of the mole LFSR.
    function automatic logic [4:0] lfsr_step(input logic [4:0] cur);
        return {cur[3:0], cur[4] ^ cur[3]};
    endfunction

    state_t        state_r;
    state_t        state_nx_s;
    logic [PW-1:0] presc_r;
    logic [PW-1:0] presc_nx_s;
    logic [7:0]    tick_r;
    logic [7:0]    tick_nx_s;
    logic [CW-1:0] phase_r;
    logic [CW-1:0] phase_nx_s;

    logic [3:0]    sync1_r;
    logic [3:0]    sync2_r;
    logic [3:0]    key_prev_r;
    logic [3:0]    key_edge_s;

    logic [4:0]    lfsr_r;
    logic [4:0]    lfsr_nx_s;
    logic          time_up_r;
    logic          time_up_nx_s;
    logic          pressed_r;
    logic          pressed_nx_s;
    logic [1:0]    key_idx_r;
    logic [1:0]    key_idx_nx_s;

    logic [7:0]    window_s;
    logic          show_done_s;
    logic          round_end_s;

    assign key_edge_s  = sync2_r & ~key_prev_r;
    assign show_done_s = (presc_r == PRESC_LAST) &&
                         (({1'b0, tick_r} + 9'd1) == {1'b0, window_s});
    assign round_end_s = (state_r == HOLD) && (state_nx_s == GAP);

`ifdef WINDOW_SHRINK_EN
    logic       shrink_flag_r;
    logic       shrink_flag_nx_s;
    logic       shrink_seen_s;
    logic [8:0] window_diff_s;
    logic [7:0] window_shrunk_s;
    logic [7:0] window_r;
    logic [7:0] window_nx_s;

    // A request on the final HOLD cycle still counts, so the flag is
    // combined with the live input before the round-end update.
    assign shrink_seen_s = shrink_flag_r | ((state_r == HOLD) & shrink);
    assign window_s      = window_r;

    // Shrink flag and narrowed window, computed in 9 bits so a step larger
    // than the current window cannot wrap.
    always_comb begin
        window_diff_s    = {1'b0, window_r} - {1'b0, SHRINK_STEP};
        window_shrunk_s  = window_r;
        shrink_flag_nx_s = 1'b0;
        window_nx_s      = window_r;
        if (window_diff_s[8] || (window_diff_s[7:0] < MIN_WINDOW)) begin
            window_shrunk_s = MIN_WINDOW;
        end else begin
            window_shrunk_s = window_diff_s[7:0];
        end
        if ((state_r == HOLD) && (state_nx_s == HOLD)) begin
            shrink_flag_nx_s = shrink_seen_s;
        end else begin
            shrink_flag_nx_s = 1'b0;
        end
        if (state_nx_s == IDLE) begin
            window_nx_s = INIT_WINDOW;
        end else if (round_end_s && shrink_seen_s) begin
            window_nx_s = window_shrunk_s;
        end else begin
            window_nx_s = window_r;
        end
    end

    // Window and shrink flag registers.
    always_ff @(posedge systemClock or posedge reset) begin
        if (reset) begin
            shrink_flag_r <= 1'b0;
            window_r      <= INIT_WINDOW;
        end else begin
            shrink_flag_r <= shrink_flag_nx_s;
            window_r      <= window_nx_s;
        end
    end
`else
    logic unused_shrink_s;

    assign unused_shrink_s = shrink;
    assign window_s        = INIT_WINDOW;
`endif

    // Next state and round counters; enable low abandons the round at once.
    always_comb begin
        state_nx_s = state_r;
        presc_nx_s = presc_r;
        tick_nx_s  = tick_r;
        phase_nx_s = phase_r;
        if (!enable) begin
            state_nx_s = IDLE;
            presc_nx_s = PRESC_ZERO;
            tick_nx_s  = 8'd0;
            phase_nx_s = PHASE_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    state_nx_s = SHOW;
                    presc_nx_s = PRESC_ZERO;
                    tick_nx_s  = 8'd0;
                    phase_nx_s = PHASE_ZERO;
                end
                SHOW: begin
                    if (show_done_s) begin
                        state_nx_s = HOLD;
                        presc_nx_s = PRESC_ZERO;
                        tick_nx_s  = 8'd0;
                        phase_nx_s = PHASE_ZERO;
                    end else if (presc_r == PRESC_LAST) begin
                        presc_nx_s = PRESC_ZERO;
                        tick_nx_s  = tick_r + 8'd1;
                    end else begin
                        presc_nx_s = presc_r + PRESC_ONE;
                    end
                end
                HOLD: begin
                    if (phase_r == HOLD_LAST) begin
                        state_nx_s = GAP;
                        phase_nx_s = PHASE_ZERO;
                    end else begin
                        phase_nx_s = phase_r + PHASE_ONE;
                    end
                end
                GAP: begin
                    if (phase_r == GAP_LAST) begin
                        state_nx_s = SHOW;
                        presc_nx_s = PRESC_ZERO;
                        tick_nx_s  = 8'd0;
                        phase_nx_s = PHASE_ZERO;
                    end else begin
                        phase_nx_s = phase_r + PHASE_ONE;
                    end
                end
                default: begin
                    state_nx_s = IDLE;
                    presc_nx_s = PRESC_ZERO;
                    tick_nx_s  = 8'd0;
                    phase_nx_s = PHASE_ZERO;
                end
            endcase
        end
    end

    // Next values of the capture, LFSR and timeUp registers.
    always_comb begin
        pressed_nx_s = pressed_r;
        key_idx_nx_s = key_idx_r;
        lfsr_nx_s    = lfsr_r;
        time_up_nx_s = (state_nx_s == HOLD);
        if ((state_nx_s == IDLE) || round_end_s) begin
            pressed_nx_s = 1'b0;
            key_idx_nx_s = 2'd0;
        end else if ((state_r == SHOW) && !pressed_r && (key_edge_s != 4'b0000)) begin
            pressed_nx_s = 1'b1;
            key_idx_nx_s = lowest_index(key_edge_s);
        end else begin
            pressed_nx_s = pressed_r;
            key_idx_nx_s = key_idx_r;
        end
        if (round_end_s) begin
            lfsr_nx_s = lfsr_step(lfsr_r);
        end else begin
            lfsr_nx_s = lfsr_r;
        end
    end

    // State, counters, key synchronizer and output registers.
    always_ff @(posedge systemClock or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            presc_r    <= PRESC_ZERO;
            tick_r     <= 8'd0;
            phase_r    <= PHASE_ZERO;
            sync1_r    <= 4'b0000;
            sync2_r    <= 4'b0000;
            key_prev_r <= 4'b0000;
            lfsr_r     <= LFSR_SEED;
            time_up_r  <= 1'b0;
            pressed_r  <= 1'b0;
            key_idx_r  <= 2'd0;
        end else begin
            state_r    <= state_nx_s;
            presc_r    <= presc_nx_s;
            tick_r     <= tick_nx_s;
            phase_r    <= phase_nx_s;
            sync1_r    <= keys;
            sync2_r    <= sync1_r;
            key_prev_r <= sync2_r;
            lfsr_r     <= lfsr_nx_s;
            time_up_r  <= time_up_nx_s;
            pressed_r  <= pressed_nx_s;
            key_idx_r  <= key_idx_nx_s;
        end
    end

    assign timeUp        = time_up_r;
    assign mole          = lfsr_r[1:0];
    assign keyPressed    = key_idx_r;
    assign pressedInTime = pressed_r;
    assign window        = window_s;

endmodule

// File: tb/tb_mole_round_timer.sv
// Directed testbench for mole_round_timer with TICK_DIV=4, INIT_WINDOW=5,
// MIN_WINDOW=2, SHRINK_STEP=2, HOLD_CYCLES=4, GAP_CYCLES=3. Outputs are
// sampled on the falling edge; inputs change right after sampling.
// Window expectations follow the WINDOW_SHRINK_EN build option.

module tb_mole_round_timer;

`ifdef WINDOW_SHRINK_EN
    localparam bit SHRINK_BUILT = 1'b1;
`else
    localparam bit SHRINK_BUILT = 1'b0;
`endif

    logic       systemClock;
    logic       reset;
    logic       enable;
    logic [3:0] keys;
    logic       shrink;
    logic       timeUp;
    logic [1:0] mole;
    logic [1:0] keyPressed;
    logic       pressedInTime;
    logic [7:0] window;

    int vec_cnt;
    int miscmp_cnt;
    int n;

    mole_round_timer #(
        .TICK_DIV    (4),
        .INIT_WINDOW (8'd5),
        .MIN_WINDOW  (8'd2),
        .SHRINK_STEP (8'd2),
        .HOLD_CYCLES (4),
        .GAP_CYCLES  (3)
    ) dut (
        .systemClock   (systemClock),
        .reset         (reset),
        .enable        (enable),
        .keys          (keys),
        .shrink        (shrink),
        .timeUp        (timeUp),
        .mole          (mole),
        .keyPressed    (keyPressed),
        .pressedInTime (pressedInTime),
        .window        (window)
    );

    initial systemClock = 1'b0;
    always #5 systemClock = ~systemClock;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt = vec_cnt + 1;
        if (got !== exp) begin
            miscmp_cnt = miscmp_cnt + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Count falling edges until timeUp reaches lvl; -1 on timeout.
    task automatic wait_tu(input logic lvl, output int cnt);
        cnt = 0;
        while ((timeUp !== lvl) && (cnt < 200)) begin
            @(negedge systemClock);
            cnt = cnt + 1;
        end
        if (timeUp !== lvl) cnt = -1;
    endtask

    initial begin
        vec_cnt    = 0;
        miscmp_cnt = 0;
        reset      = 1'b1;
        enable     = 1'b0;
        keys       = 4'b0000;
        shrink     = 1'b0;

        // Reset state
        repeat (2) @(negedge systemClock);
        check_value("rst_timeUp", 32'(timeUp), 32'd0);
        check_value("rst_mole", 32'(mole), 32'd1);
        check_value("rst_keyPressed", 32'(keyPressed), 32'd0);
        check_value("rst_pressed", 32'(pressedInTime), 32'd0);
        check_value("rst_window", 32'(window), 32'd5);
        reset = 1'b0;
        @(negedge systemClock);

        // First round: 20 SHOW cycles, timeUp high for 4
        enable = 1'b1;
        wait_tu(1'b1, n);
        check_value("r1_rise_lat", 32'(n), 32'd21);
        wait_tu(1'b0, n);
        check_value("r1_hold_len", 32'(n), 32'd4);
        check_value("r1_mole", 32'(mole), 32'd3);
        check_value("r1_window", 32'(window), 32'd5);

        // Round 2: capture key 2, ignore a later key 0 (now at sample 24)
        repeat (6) @(negedge systemClock);
        keys = 4'b0100;
        @(negedge systemClock);
        keys = 4'b0000;
        @(negedge systemClock);
        check_value("cap_early", 32'(pressedInTime), 32'd0);
        @(negedge systemClock);
        check_value("cap_pressed", 32'(pressedInTime), 32'd1);
        check_value("cap_key", 32'(keyPressed), 32'd2);
        keys = 4'b0001;
        @(negedge systemClock);
        keys = 4'b0000;
        repeat (6) @(negedge systemClock);
        check_value("second_key", 32'(keyPressed), 32'd2);
        check_value("second_pressed", 32'(pressedInTime), 32'd1);
        wait_tu(1'b1, n);
        check_value("r2_rise", 32'(n), 32'd7);
        repeat (3) @(negedge systemClock);
        check_value("last_hold_pressed", 32'(pressedInTime), 32'd1);
        check_value("last_hold_key", 32'(keyPressed), 32'd2);
        @(negedge systemClock);
        check_value("r2_timeUp_fall", 32'(timeUp), 32'd0);
        check_value("r2_clr_pressed", 32'(pressedInTime), 32'd0);
        check_value("r2_clr_key", 32'(keyPressed), 32'd0);
        check_value("r2_mole", 32'(mole), 32'd2);

        // Round 3: press during GAP ignored, simultaneous keys 1010 -> 1
        keys = 4'b0001;
        @(negedge systemClock);
        keys = 4'b0000;
        repeat (4) @(negedge systemClock);
        check_value("gap_press", 32'(pressedInTime), 32'd0);
        repeat (2) @(negedge systemClock);
        keys = 4'b1010;
        @(negedge systemClock);
        keys = 4'b0000;
        repeat (2) @(negedge systemClock);
        check_value("simul_key", 32'(keyPressed), 32'd1);
        check_value("simul_pressed", 32'(pressedInTime), 32'd1);
        wait_tu(1'b1, n);
        check_value("r3_rise", 32'(n), 32'd13);
        check_value("r3_hold_mole", 32'(mole), 32'd2);
        wait_tu(1'b0, n);
        check_value("r3_hold_len", 32'(n), 32'd4);
        check_value("r3_mole", 32'(mole), 32'd0);

        // Round 4: key edge on the last SHOW cycle is captured
        repeat (20) @(negedge systemClock);
        keys = 4'b1000;
        @(negedge systemClock);
        keys = 4'b0000;
        @(negedge systemClock);
        check_value("lastshow_tu", 32'(timeUp), 32'd0);
        @(negedge systemClock);
        check_value("lastshow_tu_rise", 32'(timeUp), 32'd1);
        check_value("lastshow_pressed", 32'(pressedInTime), 32'd1);
        check_value("lastshow_key", 32'(keyPressed), 32'd3);
        wait_tu(1'b0, n);
        check_value("r4_hold_len", 32'(n), 32'd4);
        check_value("r4_mole", 32'(mole), 32'd1);

        // Round 5: key edge on the first HOLD cycle ignored; shrink in HOLD
        repeat (21) @(negedge systemClock);
        keys = 4'b0001;
        @(negedge systemClock);
        keys = 4'b0000;
        @(negedge systemClock);
        check_value("firsthold_tu", 32'(timeUp), 32'd1);
        shrink = 1'b1;
        @(negedge systemClock);
        shrink = 1'b0;
        check_value("firsthold_pressed", 32'(pressedInTime), 32'd0);
        wait_tu(1'b0, n);
        check_value("r5_fall", 32'(n), 32'd3);
        check_value("r5_window", 32'(window), SHRINK_BUILT ? 32'd3 : 32'd5);
        check_value("r5_mole", 32'(mole), 32'd2);

        // Round 6: shrink only in GAP/SHOW leaves the window unchanged
        shrink = 1'b1;
        repeat (6) @(negedge systemClock);
        shrink = 1'b0;
        wait_tu(1'b1, n);
        check_value("r6_rise", 32'(n), SHRINK_BUILT ? 32'd9 : 32'd17);
        wait_tu(1'b0, n);
        check_value("r6_hold_len", 32'(n), 32'd4);
        check_value("r6_window", 32'(window), SHRINK_BUILT ? 32'd3 : 32'd5);
        check_value("r6_mole", 32'(mole), 32'd1);

        // Round 7: shrink on the last HOLD cycle only; 3 -> 2
        wait_tu(1'b1, n);
        check_value("r7_rise", 32'(n), SHRINK_BUILT ? 32'd15 : 32'd23);
        repeat (3) @(negedge systemClock);
        shrink = 1'b1;
        @(negedge systemClock);
        shrink = 1'b0;
        check_value("r7_tu_fall", 32'(timeUp), 32'd0);
        check_value("r7_window", 32'(window), SHRINK_BUILT ? 32'd2 : 32'd5);
        check_value("r7_mole", 32'(mole), 32'd2);

        // Round 8: shrink through HOLD at the floor stays at 2
        wait_tu(1'b1, n);
        check_value("r8_rise", 32'(n), SHRINK_BUILT ? 32'd11 : 32'd23);
        shrink = 1'b1;
        wait_tu(1'b0, n);
        shrink = 1'b0;
        check_value("r8_hold_len", 32'(n), 32'd4);
        check_value("r8_window", 32'(window), SHRINK_BUILT ? 32'd2 : 32'd5);
        check_value("r8_mole", 32'(mole), 32'd1);

        // Round 9: capture a key, then drop enable mid-SHOW
        repeat (5) @(negedge systemClock);
        keys = 4'b0100;
        @(negedge systemClock);
        keys = 4'b0000;
        repeat (2) @(negedge systemClock);
        check_value("r9_pressed", 32'(pressedInTime), 32'd1);
        enable = 1'b0;
        @(negedge systemClock);
        check_value("dis_show_tu", 32'(timeUp), 32'd0);
        check_value("dis_show_pressed", 32'(pressedInTime), 32'd0);
        check_value("dis_show_key", 32'(keyPressed), 32'd0);
        check_value("dis_show_window", 32'(window), 32'd5);
        check_value("dis_show_mole", 32'(mole), 32'd1);

        // Round 10: drop enable in HOLD; timeUp drops, LFSR does not step
        enable = 1'b1;
        wait_tu(1'b1, n);
        check_value("r10_rise", 32'(n), 32'd21);
        enable = 1'b0;
        @(negedge systemClock);
        check_value("dis_hold_tu", 32'(timeUp), 32'd0);
        check_value("dis_hold_mole", 32'(mole), 32'd1);

        // Round 11: full round steps the LFSR to 01011
        enable = 1'b1;
        wait_tu(1'b1, n);
        check_value("r11_rise", 32'(n), 32'd21);
        wait_tu(1'b0, n);
        check_value("r11_hold_len", 32'(n), 32'd4);
        check_value("r11_mole", 32'(mole), 32'd3);

        // Round 12: asynchronous reset during HOLD
        wait_tu(1'b1, n);
        check_value("r12_rise", 32'(n), 32'd23);
        #2;
        reset = 1'b1;
        #1;
        check_value("arst_tu", 32'(timeUp), 32'd0);
        check_value("arst_mole", 32'(mole), 32'd1);
        check_value("arst_window", 32'(window), 32'd5);
        check_value("arst_pressed", 32'(pressedInTime), 32'd0);
        @(negedge systemClock);
        reset  = 1'b0;
        enable = 1'b0;
        @(negedge systemClock);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule
